// File: rtl/eqy_miter_monitor.sv
// Gold-vs-gate equivalence monitor: masked per-channel compare,
// sticky fail status, first-mismatch capture and saturating counters.
module eqy_miter_monitor #(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 16,
  parameter int HOLDOFF      = 4,
  parameter int STOP_ON_FAIL = 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm_i,
  input  logic                    stop_i,
  input  logic                    valid_i,
  input  logic [NUM_CH*WIDTH-1:0] gold_i,
  input  logic [NUM_CH*WIDTH-1:0] gate_i,
  input  logic [NUM_CH*WIDTH-1:0] care_i,
  output logic                    busy_o,
  output logic                    fail_o,
  output logic                    pass_o,
  output logic [NUM_CH-1:0]       mis_vec_o,
  output logic [CH_W-1:0]         first_ch_o,
  output logic [CNT_W-1:0]        first_cyc_o,
  output logic [CNT_W-1:0]        check_cnt_o,
  output logic [CNT_W-1:0]        mis_cnt_o
);

  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_FAIL, S_DONE
  } state_t;

  state_t            r_state, w_nxt;
  logic [NUM_CH-1:0] w_diff, r_diff;
  logic              r_s1_valid;
  logic [CH_W-1:0]   w_low;
  logic              w_any, w_hold_end;
  logic [HW-1:0]     r_hold;
  logic [CNT_W-1:0]  r_chk, r_mis, r_fcy;
  logic [NUM_CH-1:0] r_mvec;
  logic [CH_W-1:0]   r_fch;
  logic              r_fail;

  // Per-channel masked difference of the raw inputs
  always_comb begin
    w_diff = '0;
    for (int c = 0; c < NUM_CH; c++)
      w_diff[c] = |((gold_i[c*WIDTH +: WIDTH] ^ gate_i[c*WIDTH +: WIDTH])
                    & care_i[c*WIDTH +: WIDTH]);
  end

  // Stage 1: register the compare; arm drops a sample in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff     <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_diff     <= w_diff;
      r_s1_valid <= valid_i && !arm_i;
    end
  end

  // Lowest mismatching channel index of the registered compare
  always_comb begin
    w_low = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (r_diff[c]) w_low = CH_W'(c);
  end

  assign w_any      = |r_diff;
  assign w_hold_end = (HOLDOFF > 0) && (r_hold == HW'(HOLDOFF - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Next state; arm beats stop and every other condition
  always_comb begin
    w_nxt = r_state;
    if (arm_i) begin
      w_nxt = (HOLDOFF > 0) ? S_SETTLE : S_CHECK;
    end else begin
      unique case (r_state)
        S_SETTLE:
          if (stop_i)                        w_nxt = S_DONE;
          else if (r_s1_valid && w_hold_end) w_nxt = S_CHECK;
        S_CHECK:
          if (stop_i) w_nxt = S_DONE;
          else if ((STOP_ON_FAIL != 0) && r_s1_valid && w_any)
            w_nxt = S_FAIL;
        S_FAIL:
          if (stop_i) w_nxt = S_DONE;
        default: w_nxt = r_state;
      endcase
    end
  end

  // Holdoff count, check/mismatch counters and sticky status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_chk  <= '0;
      r_mis  <= '0;
      r_fcy  <= '0;
      r_fch  <= '0;
      r_mvec <= '0;
      r_fail <= 1'b0;
    end else if (arm_i) begin
      r_hold <= '0;
      r_chk  <= '0;
      r_mis  <= '0;
      r_fcy  <= '0;
      r_fch  <= '0;
      r_mvec <= '0;
      r_fail <= 1'b0;
    end else if (r_state == S_SETTLE && r_s1_valid) begin
      r_hold <= r_hold + 1'b1;
    end else if (r_state == S_CHECK && r_s1_valid) begin
      if (r_chk != MAX) r_chk <= r_chk + 1'b1;
      if (w_any) begin
        if (r_mis != MAX) r_mis <= r_mis + 1'b1;
        r_mvec <= r_mvec | r_diff;
        r_fail <= 1'b1;
        if (!r_fail) begin
          r_fch <= w_low;
          r_fcy <= r_chk;
        end
      end
    end
  end

  // State-decoded outputs
  always_comb begin
    busy_o = (r_state == S_SETTLE) || (r_state == S_CHECK);
    pass_o = (r_state == S_DONE) && !r_fail && (r_chk != '0);
  end

  assign fail_o      = r_fail;
  assign mis_vec_o   = r_mvec;
  assign first_ch_o  = r_fch;
  assign first_cyc_o = r_fcy;
  assign check_cnt_o = r_chk;
  assign mis_cnt_o   = r_mis;

endmodule
